rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one 8-way resource between eight requesters. It picks one requester at a time, drives the 3-bit select, and drives the active-low one-hot grant through the existing 3-to-8 active-low decoder. Ownership is bounded by a hold limit, and a released requester goes to the lowest priority. It sits in front of any 8-way resource that the team currently drives from a free-running or software-set select.

## Interface
Parameters:
- HOLD_MAX, default 16: maximum consecutive cycles one requester may hold the grant. Legal range 1..256.

Ports:
- i_clk  input  1  single clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_req  input  8  request vector, active high; bit k = requester k.
- i_done  input  1  current owner releases the grant; sampled only in GRANT.
- o_sel  output  3  index of the current or most recent winner, registered.
- o_gnt_n  output  8  active-low one-hot grant, registered; 8'hFF = no grant.
- o_busy  output  1  high while in GRANT.
- o_preempt  output  1  one-cycle pulse when a grant ends because HOLD_MAX expired.

## Operation
- Reset values: state=IDLE, ptr=0, hold_cnt=0, o_sel=0, o_gnt_n=8'hFF, o_busy=0, o_preempt=0.
- FSM has two states: IDLE and GRANT.
- **IDLE:**
  - If i_req==0: stay in IDLE, outputs unchanged, o_preempt=0.
  - Otherwise, winner = first set bit of i_req scanning ptr, ptr+1, …, ptr+7, all mod 8 (wraps 7→0).
  - On that edge: o_sel<=winner, o_gnt_n<=decode(winner), o_busy<=1, ptr<=(winner+1) mod 8, hold_cnt<=0, state<=GRANT.
- **GRANT:** release condition rel = i_done | ~i_req[o_sel] | (hold_cnt==HOLD_MAX-1).
  - If rel: state<=IDLE, o_gnt_n<=8'hFF, o_busy<=0, hold_cnt<=0.
  - On release, o_preempt<=1 only if the release came from hold expiry alone (i_done=0 and i_req[o_sel]=1). Otherwise o_preempt<=0.
  - If no rel: hold_cnt<=hold_cnt+1.
- o_sel keeps the last winner through IDLE.
- o_gnt_n is never anything other than 8'hFF or exactly one zero bit.
- Simultaneous events:
  - i_done and hold expiry in the same cycle → release, o_preempt=0.
  - A request from the owner in the release cycle is ignored; it competes again from IDLE.
- A single continuous requester is re-granted after one idle cycle, because the scan wraps back to it.
- hold_cnt width is $clog2(HOLD_MAX) with a minimum of 1 bit. hold_cnt never exceeds HOLD_MAX-1.

## Timing
- Grant latency: a request present at IDLE edge N gives o_gnt_n low after edge N. Comb-to-register is 1 cycle; there is no combinational path from input to output.
- Minimum grant length is 1 cycle. Maximum is HOLD_MAX cycles.
- There is exactly one IDLE cycle (o_gnt_n=8'hFF) between any two grants. This keeps grants from overlapping at the resource.
- Release takes effect on the edge where rel is sampled high. o_gnt_n is 8'hFF from that edge on.
- Asynchronous reset in the middle of a grant forces all outputs to their reset values immediately, without waiting for a clock edge. The first grant after reset deasserts can occur on the first rising edge.

## Structure
- Shared header holds the localparams:
  - N_REQ=8, SEL_W=3, GNT_NONE=8'hFF;
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- Sub-module: one instance of the existing combinational 3-to-8 active-low decoder (decoder38_12_base). It decodes the next-winner index, and its output is registered into o_gnt_n.
- The priority scan is a combinational function in the top: rotate i_req right by ptr, priority-encode the result, then add ptr mod 8.

## Test plan
1. Reset: hold i_rst_n low mid-grant, with no clock edge → o_gnt_n=8'hFF, o_sel=0, o_busy=0 immediately.
2. Single request: i_req=8'h08 at edge 1 → o_sel=3 and o_gnt_n=8'hF7 after edge 1. Then i_done=1 at edge 4 → o_gnt_n=8'hFF after edge 4, o_preempt=0.
3. Full contention, HOLD_MAX=4, i_req=8'hFF, i_done=0 → winners 0,1,…,7,0 in turn.
   - Each grant lasts 4 cycles, followed by 1 idle cycle.
   - o_preempt pulses at every release.
4. Wrap-around: after granting requester 6 (ptr=7), apply i_req=8'h41 → winner 0 and o_gnt_n=8'hFE; then winner 6 on the next arbitration.
5. Withdrawal: owner 2 drops i_req[2] in its second grant cycle → release on that edge with o_preempt=0, and the next waiting requester wins after one idle cycle.
6. HOLD_MAX=1, i_req=8'h01 held continuously → o_gnt_n alternates FE, FF, FE, FF…, and o_preempt pulses on every release.

Source files
------------

// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state type for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

  localparam int         N_REQ    = 8;
  localparam int         SEL_W    = 3;
  localparam logic [7:0] GNT_NONE = 8'hFF;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_t;

endpackage

// File: rtl/decoder38_12_base.sv
// Combinational 3-to-8 decoder with active-low one-hot output.
module decoder38_12_base (
  input  logic [2:0] a_i,
  output logic [7:0] y_n_o
);

  always_comb begin
    y_n_o      = 8'hFF;
    y_n_o[a_i] = 1'b0;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for eight requesters with bounded hold time.
// Registered select/grant; one idle cycle separates every pair of grants.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_done,
  output logic [SEL_W-1:0] o_sel,
  output logic [N_REQ-1:0] o_gnt_n,
  output logic             o_busy,
  output logic             o_preempt
);

  localparam int             HCW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_MAX - 1);

  state_t           state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [HCW-1:0]   hold_q;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] gnt_n_q;
  logic             busy_q;
  logic             preempt_q;

  logic [SEL_W-1:0] win_d;
  logic [N_REQ-1:0] gnt_n_d;
  logic             rel;

  // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [SEL_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   idx;
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = SEL_W'(k);
    end
    return idx + ptr;
  endfunction

  assign win_d = rr_pick(i_req, ptr_q);
  assign rel   = i_done | ~i_req[sel_q] | (hold_q == HOLD_LAST);

  decoder38_12_base u_dec (
    .a_i   (win_d),
    .y_n_o (gnt_n_d)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      sel_q     <= '0;
      gnt_n_q   <= GNT_NONE;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          preempt_q <= 1'b0;
          if (|i_req) begin
            sel_q   <= win_d;
            gnt_n_q <= gnt_n_d;
            busy_q  <= 1'b1;
            ptr_q   <= win_d + SEL_W'(1);
            hold_q  <= '0;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (rel) begin
            state_q   <= S_IDLE;
            gnt_n_q   <= GNT_NONE;
            busy_q    <= 1'b0;
            hold_q    <= '0;
            // Only a forced end of a still-wanted grant counts as preemption.
            preempt_q <= ~i_done & i_req[sel_q];
          end else begin
            hold_q    <= hold_q + HCW'(1);
            preempt_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_sel     = sel_q;
  assign o_gnt_n   = gnt_n_q;
  assign o_busy    = busy_q;
  assign o_preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed checks of rr_arbiter8 at HOLD_MAX of 16, 4 and 1.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b, req_c;
  logic       done_a, done_b, done_c;
  logic [2:0] sel_a, sel_b, sel_c;
  logic [7:0] gnt_a, gnt_b, gnt_c;
  logic       busy_a, busy_b, busy_c;
  logic       pre_a, pre_b, pre_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.HOLD_MAX(16)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_a), .i_done(done_a),
    .o_sel(sel_a), .o_gnt_n(gnt_a), .o_busy(busy_a), .o_preempt(pre_a)
  );

  rr_arbiter8 #(.HOLD_MAX(4)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_b), .i_done(done_b),
    .o_sel(sel_b), .o_gnt_n(gnt_b), .o_busy(busy_b), .o_preempt(pre_b)
  );

  rr_arbiter8 #(.HOLD_MAX(1)) u_dut_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_c), .i_done(done_c),
    .o_sel(sel_c), .o_gnt_n(gnt_c), .o_busy(busy_c), .o_preempt(pre_c)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_gnt;

    rst_n  = 1'b0;
    req_a  = '0; req_b  = '0; req_c  = '0;
    done_a = 1'b0; done_b = 1'b0; done_c = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt_a, 8'hFF);
    check("rst_sel", {5'd0, sel_a}, 8'd0);
    check("rst_busy", {7'd0, busy_a}, 8'd0);
    check("rst_pre", {7'd0, pre_a}, 8'd0);
    rst_n = 1'b1;

    // Single requester 3, released by done on its fourth grant edge.
    req_a = 8'h08;
    tick();
    check("single_sel", {5'd0, sel_a}, 8'd3);
    check("single_gnt", gnt_a, 8'hF7);
    check("single_busy", {7'd0, busy_a}, 8'd1);
    tick();
    tick();
    done_a = 1'b1;
    tick();
    check("single_rel_gnt", gnt_a, 8'hFF);
    check("single_rel_pre", {7'd0, pre_a}, 8'd0);
    check("single_rel_busy", {7'd0, busy_a}, 8'd0);
    check("single_keep_sel", {5'd0, sel_a}, 8'd3);
    done_a = 1'b0;
    req_a  = 8'h00;

    // Full contention at HOLD_MAX=4: winners 0..7 then 0 again.
    req_b = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_gnt = 8'hFF;
      exp_gnt[k % 8] = 1'b0;
      tick();
      check("rr_sel", {5'd0, sel_b}, 8'(k % 8));
      check("rr_gnt", gnt_b, exp_gnt);
      check("rr_pre_lo", {7'd0, pre_b}, 8'd0);
      tick();
      tick();
      tick();
      check("rr_hold_gnt", gnt_b, exp_gnt);
      tick();
      check("rr_idle_gnt", gnt_b, 8'hFF);
      check("rr_pre", {7'd0, pre_b}, 8'd1);
    end
    req_b = 8'h00;

    // Wrap-around: ptr=1 so 8'h40 gives owner 6, leaving ptr=7.
    req_b = 8'h40;
    tick();
    check("wrap_first_sel", {5'd0, sel_b}, 8'd6);
    req_b  = 8'h41;
    done_b = 1'b1;
    tick();
    check("wrap_rel_gnt", gnt_b, 8'hFF);
    check("wrap_rel_pre", {7'd0, pre_b}, 8'd0);
    done_b = 1'b0;
    tick();
    check("wrap_win0_sel", {5'd0, sel_b}, 8'd0);
    check("wrap_win0_gnt", gnt_b, 8'hFE);
    done_b = 1'b1;
    tick();
    check("wrap_rel2_gnt", gnt_b, 8'hFF);
    done_b = 1'b0;
    tick();
    check("wrap_win6_sel", {5'd0, sel_b}, 8'd6);
    check("wrap_win6_gnt", gnt_b, 8'hBF);
    done_b = 1'b1;
    req_b  = 8'h00;
    tick();
    done_b = 1'b0;

    // Withdrawal: ptr=4 on dut_a, 8'h0C gives owner 2, requester 3 waits.
    req_a = 8'h0C;
    tick();
    check("wd_sel", {5'd0, sel_a}, 8'd2);
    check("wd_gnt", gnt_a, 8'hFB);
    tick();
    check("wd_hold_gnt", gnt_a, 8'hFB);
    req_a = 8'h08;
    tick();
    check("wd_rel_gnt", gnt_a, 8'hFF);
    check("wd_rel_pre", {7'd0, pre_a}, 8'd0);
    tick();
    check("wd_next_sel", {5'd0, sel_a}, 8'd3);
    check("wd_next_gnt", gnt_a, 8'hF7);
    req_a  = 8'h00;
    done_a = 1'b1;
    tick();
    done_a = 1'b0;

    // HOLD_MAX=1 with a continuous single requester.
    req_c = 8'h01;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("h1_gnt", gnt_c, 8'hFE);
      check("h1_pre_lo", {7'd0, pre_c}, 8'd0);
      tick();
      check("h1_idle", gnt_c, 8'hFF);
      check("h1_pre", {7'd0, pre_c}, 8'd1);
    end
    req_c = 8'h00;

    // Asynchronous reset in the middle of a grant to requester 6.
    req_a = 8'h40;
    tick();
    check("mid_sel", {5'd0, sel_a}, 8'd6);
    check("mid_gnt", gnt_a, 8'hBF);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt_a, 8'hFF);
    check("arst_sel", {5'd0, sel_a}, 8'd0);
    check("arst_busy", {7'd0, busy_a}, 8'd0);
    check("arst_pre", {7'd0, pre_a}, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
